// File: rtl/cv32e40p_pkg2_ft.sv
// ----------------------------------------------------------------------------
// cv32e40p_pkg2_ft
// Shared constants for the fault-tolerance status manager: register offsets,
// PENDING bit positions, the maximum number of monitored blocks, and the
// register address decoder used by the top level.
// ----------------------------------------------------------------------------
package cv32e40p_pkg2_ft;

  localparam int unsigned FT_N_BLOCKS_MAX = 8;

  localparam logic [7:0] FT_ADDR_STATUS    = 8'h00;
  localparam logic [7:0] FT_ADDR_FATAL     = 8'h04;
  localparam logic [7:0] FT_ADDR_PENDING   = 8'h08;
  localparam logic [7:0] FT_ADDR_ENABLE    = 8'h0C;
  localparam logic [7:0] FT_ADDR_MASK_BASE = 8'h10;
  localparam logic [7:0] FT_ADDR_DET_BASE  = 8'h40;
  localparam logic [7:0] FT_ADDR_COR_BASE  = 8'h80;

  localparam int unsigned FT_PEND_BROKEN = 0;
  localparam int unsigned FT_PEND_FATAL  = 1;

  typedef enum logic [2:0] {
    FT_SEL_NONE,
    FT_SEL_STATUS,
    FT_SEL_FATAL,
    FT_SEL_PENDING,
    FT_SEL_ENABLE,
    FT_SEL_MASK,
    FT_SEL_DET,
    FT_SEL_COR
  } ft_sel_e;

  typedef struct packed {
    ft_sel_e    sel;
    logic [2:0] idx;
  } ft_dec_t;

  function automatic logic [1:0] ft_popcnt3(input logic [2:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

  // Decodes a word address into a register select and block index.
  // Per-block banks beyond n_blocks decode to FT_SEL_NONE.
  function automatic ft_dec_t ft_decode(input logic [5:0] word,
                                        input int unsigned n_blocks);
    ft_dec_t    d;
    logic [5:0] rel_mask;
    logic [5:0] rel_det;
    logic [5:0] rel_cor;
    d.sel    = FT_SEL_NONE;
    d.idx    = '0;
    rel_mask = word - FT_ADDR_MASK_BASE[7:2];
    rel_det  = word - FT_ADDR_DET_BASE[7:2];
    rel_cor  = word - FT_ADDR_COR_BASE[7:2];
    if (word == FT_ADDR_STATUS[7:2]) begin
      d.sel = FT_SEL_STATUS;
    end else if (word == FT_ADDR_FATAL[7:2]) begin
      d.sel = FT_SEL_FATAL;
    end else if (word == FT_ADDR_PENDING[7:2]) begin
      d.sel = FT_SEL_PENDING;
    end else if (word == FT_ADDR_ENABLE[7:2]) begin
      d.sel = FT_SEL_ENABLE;
    end else if (word >= FT_ADDR_MASK_BASE[7:2] && 32'(rel_mask) < n_blocks) begin
      d.sel = FT_SEL_MASK;
      d.idx = rel_mask[2:0];
    end else if (word >= FT_ADDR_DET_BASE[7:2] && 32'(rel_det) < n_blocks) begin
      d.sel = FT_SEL_DET;
      d.idx = rel_det[2:0];
    end else if (word >= FT_ADDR_COR_BASE[7:2] && 32'(rel_cor) < n_blocks) begin
      d.sel = FT_SEL_COR;
      d.idx = rel_cor[2:0];
    end
    return d;
  endfunction

endpackage

// File: rtl/cv32e40p_ft_sat_counter.sv
// ----------------------------------------------------------------------------
// cv32e40p_ft_sat_counter
// Saturating up-counter with synchronous clear; clear wins over increment.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc_i      : increment by one this cycle (holds at all-ones)
//   clr_i      : clear to zero this cycle
//   cnt_o      : current count
// ----------------------------------------------------------------------------
module cv32e40p_ft_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cv32e40p_ft_status_manager.sv
// ----------------------------------------------------------------------------
// cv32e40p_ft_status_manager
// Software-visible status/control for N_BLOCKS triplicated blocks: per-block
// error counters, breakage status, force-broken masks and an interrupt.
//   clk, rst_n        : clock, asynchronous active-low reset
//   err_detected_i    : per-block voter error-detected flag
//   err_corrected_i   : per-block voter error-corrected flag
//   is_broken_i       : per-block 3-bit replica-broken flags (block k at [3k+:3])
//   set_broken_o      : per-block 3-bit force-broken drive (block k at [3k+:3])
//   req_i/we_i/addr_i/wdata_i : register access request
//   gnt_o             : grant (same cycle as request)
//   rvalid_o/rdata_o  : response, one cycle after the request
//   irq_o             : level interrupt, |(PENDING & ENABLE), registered
// ----------------------------------------------------------------------------
module cv32e40p_ft_status_manager
  import cv32e40p_pkg2_ft::*;
#(
  parameter int unsigned N_BLOCKS = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_BLOCKS-1:0]   err_detected_i,
  input  logic [N_BLOCKS-1:0]   err_corrected_i,
  input  logic [3*N_BLOCKS-1:0] is_broken_i,
  output logic [3*N_BLOCKS-1:0] set_broken_o,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [7:0]            addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  irq_o
);

  ft_dec_t dec;
  logic    wr_en;
  logic    unused_ok;

  assign dec       = ft_decode(addr_i[7:2], N_BLOCKS);
  assign wr_en     = req_i & we_i;
  assign gnt_o     = req_i & rst_n;
  assign unused_ok = ^{addr_i[1:0], wdata_i[31:3]};

  // Views padded to the maximum block count so a 3-bit index is always legal.
  logic [2:0]       brk_v  [FT_N_BLOCKS_MAX];
  logic [2:0]       mask_v [FT_N_BLOCKS_MAX];
  logic [CNT_W-1:0] det_v  [FT_N_BLOCKS_MAX];
  logic [CNT_W-1:0] cor_v  [FT_N_BLOCKS_MAX];

  logic [2:0]          mask_q [N_BLOCKS];
  logic [2:0]          mask_d [N_BLOCKS];
  logic [N_BLOCKS-1:0] status;
  logic [N_BLOCKS-1:0] fatal;

  for (genvar g = 0; g < FT_N_BLOCKS_MAX; g++) begin : g_blk
    if (g < N_BLOCKS) begin : g_on
      logic det_clr;
      logic cor_clr;

      assign brk_v[g]  = is_broken_i[3*g +: 3];
      assign mask_v[g] = mask_q[g];
      assign status[g] = |brk_v[g];
      assign fatal[g]  = ft_popcnt3(brk_v[g]) >= 2'd2;
      assign set_broken_o[3*g +: 3] = mask_q[g];

      assign det_clr = wr_en && (dec.sel == FT_SEL_DET) && (dec.idx == 3'(g));
      assign cor_clr = wr_en && (dec.sel == FT_SEL_COR) && (dec.idx == 3'(g));

      cv32e40p_ft_sat_counter #(.CNT_W(CNT_W)) u_det_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (err_detected_i[g]),
        .clr_i (det_clr),
        .cnt_o (det_v[g])
      );

      cv32e40p_ft_sat_counter #(.CNT_W(CNT_W)) u_cor_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (err_corrected_i[g]),
        .clr_i (cor_clr),
        .cnt_o (cor_v[g])
      );
    end else begin : g_off
      assign brk_v[g]  = '0;
      assign mask_v[g] = '0;
      assign det_v[g]  = '0;
      assign cor_v[g]  = '0;
    end
  end

  logic [3*N_BLOCKS-1:0] brk_prev_q;
  logic [N_BLOCKS-1:0]   fatal_prev_q;
  logic [1:0]            pending_q, pending_d;
  logic [1:0]            enable_q, enable_d;
  logic                  irq_q, irq_d;
  logic                  rvalid_q, rvalid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  mask_wr_ok;
  logic                  brk_rise;
  logic                  fatal_rise;

  // A mask write is accepted only if at least two replicas stay healthy
  // once combined with the replicas already reported broken.
  always_comb begin
    mask_wr_ok = ft_popcnt3(wdata_i[2:0] | brk_v[dec.idx]) <= 2'd1;
    for (int unsigned k = 0; k < N_BLOCKS; k++) begin
      mask_d[k] = mask_q[k];
      if (wr_en && (dec.sel == FT_SEL_MASK) && (dec.idx == 3'(k)) && mask_wr_ok) begin
        mask_d[k] = wdata_i[2:0];
      end
    end
  end

  always_comb begin
    brk_rise   = |(is_broken_i & ~brk_prev_q);
    fatal_rise = |(fatal & ~fatal_prev_q);

    // Clear first, then set, so a same-cycle event survives the W1C.
    pending_d = pending_q;
    if (wr_en && (dec.sel == FT_SEL_PENDING)) begin
      pending_d = pending_q & ~wdata_i[1:0];
    end
    if (brk_rise) begin
      pending_d[FT_PEND_BROKEN] = 1'b1;
    end
    if (fatal_rise) begin
      pending_d[FT_PEND_FATAL] = 1'b1;
    end

    enable_d = enable_q;
    if (wr_en && (dec.sel == FT_SEL_ENABLE)) begin
      enable_d = wdata_i[1:0];
    end

    irq_d    = |(pending_q & enable_q);
    rvalid_d = req_i;

    rdata_d = '0;
    if (req_i && !we_i) begin
      case (dec.sel)
        FT_SEL_STATUS:  rdata_d = 32'(status);
        FT_SEL_FATAL:   rdata_d = 32'(fatal);
        FT_SEL_PENDING: rdata_d = {30'b0, pending_q};
        FT_SEL_ENABLE:  rdata_d = {30'b0, enable_q};
        FT_SEL_MASK:    rdata_d = {25'b0, brk_v[dec.idx], 1'b0, mask_v[dec.idx]};
        FT_SEL_DET:     rdata_d = 32'(det_v[dec.idx]);
        FT_SEL_COR:     rdata_d = 32'(cor_v[dec.idx]);
        default:        rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N_BLOCKS; k++) begin
        mask_q[k] <= '0;
      end
      brk_prev_q   <= '0;
      fatal_prev_q <= '0;
      pending_q    <= '0;
      enable_q     <= '0;
      irq_q        <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
    end else begin
      for (int unsigned k = 0; k < N_BLOCKS; k++) begin
        mask_q[k] <= mask_d[k];
      end
      brk_prev_q   <= is_broken_i;
      fatal_prev_q <= fatal;
      pending_q    <= pending_d;
      enable_q     <= enable_d;
      irq_q        <= irq_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_cv32e40p_ft_status_manager.sv
module tb_cv32e40p_ft_status_manager;

  localparam int NB   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NB-1:0]   err_detected_i;
  logic [NB-1:0]   err_corrected_i;
  logic [3*NB-1:0] is_broken_i;
  logic [3*NB-1:0] set_broken_o;
  logic            req_i;
  logic            we_i;
  logic [7:0]      addr_i;
  logic [31:0]     wdata_i;
  logic            gnt_o;
  logic            rvalid_o;
  logic [31:0]     rdata_o;
  logic            irq_o;

  always #5 clk = ~clk;

  cv32e40p_ft_status_manager #(.N_BLOCKS(NB), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .err_detected_i  (err_detected_i),
    .err_corrected_i (err_corrected_i),
    .is_broken_i     (is_broken_i),
    .set_broken_o    (set_broken_o),
    .req_i           (req_i),
    .we_i            (we_i),
    .addr_i          (addr_i),
    .wdata_i         (wdata_i),
    .gnt_o           (gnt_o),
    .rvalid_o        (rvalid_o),
    .rdata_o         (rdata_o),
    .irq_o           (irq_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: register file as plain integers.
  int          m_det  [NB];
  int          m_cor  [NB];
  int          m_mask [NB];
  int          m_pend;
  int          m_en;
  logic [3*NB-1:0] m_prev_brk;
  int          m_prev_fatal;
  int          m_rvalid;
  logic [31:0] m_rdata;
  int          m_irq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int brkof(input int k);
    return int'((is_broken_i >> (3 * k)) & 12'h7);
  endfunction

  function automatic int fatal_bits();
    int r = 0;
    for (int k = 0; k < NB; k++)
      if ($countones(3'(brkof(k))) >= 2) r |= (1 << k);
    return r;
  endfunction

  function automatic int status_bits();
    int r = 0;
    for (int k = 0; k < NB; k++)
      if (brkof(k) != 0) r |= (1 << k);
    return r;
  endfunction

  function automatic logic [31:0] model_read(input int a);
    if (a == 'h00) return 32'(status_bits());
    if (a == 'h04) return 32'(fatal_bits());
    if (a == 'h08) return 32'(m_pend);
    if (a == 'h0C) return 32'(m_en);
    if (a >= 'h10 && a < 'h10 + 4 * NB) return 32'((brkof((a - 'h10) / 4) << 4) | m_mask[(a - 'h10) / 4]);
    if (a >= 'h40 && a < 'h40 + 4 * NB) return 32'(m_det[(a - 'h40) / 4]);
    if (a >= 'h80 && a < 'h80 + 4 * NB) return 32'(m_cor[(a - 'h80) / 4]);
    return 32'd0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NB; k++) begin
      m_det[k] = 0; m_cor[k] = 0; m_mask[k] = 0;
    end
    m_pend = 0; m_en = 0; m_prev_brk = '0; m_prev_fatal = 0;
    m_rvalid = 0; m_rdata = '0; m_irq = 0;
  endtask

  // Advance the model across one clock edge using the currently driven inputs.
  task automatic model_step();
    int          a;
    bit          wr;
    int          fat;
    int          nrv;
    logic [31:0] nrd;
    int          nirq;
    int          w;
    a    = int'(addr_i) & 'hFC;
    wr   = req_i && we_i;
    w    = int'(wdata_i[2:0]);
    fat  = fatal_bits();
    nrv  = int'(req_i);
    nrd  = (req_i && !we_i) ? model_read(a) : 32'd0;
    nirq = ((m_pend & m_en) != 0) ? 1 : 0;

    if (wr && a == 'h08) m_pend = m_pend & ~(int'(wdata_i[1:0]));
    if ((is_broken_i & ~m_prev_brk) != 0) m_pend |= 1;
    if ((fat & ~m_prev_fatal) != 0) m_pend |= 2;
    if (wr && a == 'h0C) m_en = int'(wdata_i[1:0]);
    if (wr && a >= 'h10 && a < 'h10 + 4 * NB) begin
      if ($countones(3'(w | brkof((a - 'h10) / 4))) <= 1) m_mask[(a - 'h10) / 4] = w;
    end
    for (int k = 0; k < NB; k++) begin
      if (wr && a == 'h40 + 4 * k) m_det[k] = 0;
      else if (err_detected_i[k] && m_det[k] < CMAX) m_det[k]++;
      if (wr && a == 'h80 + 4 * k) m_cor[k] = 0;
      else if (err_corrected_i[k] && m_cor[k] < CMAX) m_cor[k]++;
    end
    m_prev_brk   = is_broken_i;
    m_prev_fatal = fat;
    m_rvalid = nrv; m_rdata = nrd; m_irq = nirq;
  endtask

  task automatic compare_all();
    logic [3*NB-1:0] exp_sb;
    for (int k = 0; k < NB; k++) exp_sb[3*k +: 3] = 3'(m_mask[k]);
    check("rvalid", 32'(rvalid_o), 32'(m_rvalid));
    check("rdata", rdata_o, m_rdata);
    check("irq", 32'(irq_o), 32'(m_irq));
    check("set_broken", 32'(set_broken_o), 32'(exp_sb));
    check("gnt", 32'(gnt_o), 32'(req_i & rst_n));
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic acc(input logic r, input logic w, input logic [7:0] a, input logic [31:0] d);
    req_i = r; we_i = w; addr_i = a; wdata_i = d;
  endtask

  int addr_tab [16] = '{'h00, 'h04, 'h08, 'h0C, 'h10, 'h14, 'h1C, 'h20,
                        'h40, 'h44, 'h4C, 'h50, 'h80, 'h84, 'h8C, 'hFC};

  initial begin
    rst_n = 1'b0;
    err_detected_i = '0; err_corrected_i = '0; is_broken_i = '0;
    acc(1'b0, 1'b0, 8'h00, 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Detected counter: 5 cycles of errors, then read.
    err_detected_i = 4'b0010;
    repeat (5) tick();
    err_detected_i = '0;
    acc(1'b1, 1'b0, 8'h44, 32'h0); tick();
    check("det1_rdata", rdata_o, 32'd5);
    check("det1_rvalid", 32'(rvalid_o), 32'd1);
    acc(1'b0, 1'b0, 8'h00, 32'h0); tick();
    check("rvalid_drop", 32'(rvalid_o), 32'd0);

    // Corrected counter saturation and clear-wins.
    err_corrected_i = 4'b0001;
    repeat (20) tick();
    acc(1'b1, 1'b0, 8'h80, 32'h0); tick();
    check("cor0_sat", rdata_o, 32'd15);
    acc(1'b1, 1'b1, 8'h80, 32'hDEAD); tick();
    check("wr_rdata_zero", rdata_o, 32'd0);
    acc(1'b1, 1'b0, 8'h83, 32'h0); tick();
    check("cor0_cleared", rdata_o, 32'd0);
    err_corrected_i = '0;

    // Mask write and protection against unvotable blocks.
    acc(1'b1, 1'b1, 8'h10, 32'h1); tick();
    check("mask0_drive", 32'(set_broken_o[2:0]), 32'd1);
    acc(1'b1, 1'b1, 8'h10, 32'h3); tick();
    acc(1'b1, 1'b0, 8'h10, 32'h0); tick();
    check("mask0_kept", rdata_o, 32'h1);
    acc(1'b1, 1'b1, 8'h10, 32'h0); tick();

    // Pending / fatal / irq.
    acc(1'b1, 1'b1, 8'h0C, 32'h3); tick();
    acc(1'b0, 1'b0, 8'h00, 32'h0);
    is_broken_i = 12'h0C0; tick();
    acc(1'b1, 1'b0, 8'h08, 32'h0); tick();
    check("pending_both", rdata_o, 32'h3);
    check("irq_set", 32'(irq_o), 32'd1);
    acc(1'b1, 1'b0, 8'h04, 32'h0); tick();
    check("fatal_b2", rdata_o, 32'h4);
    acc(1'b1, 1'b1, 8'h08, 32'h3); tick();
    acc(1'b0, 1'b0, 8'h00, 32'h0); tick();
    check("irq_clear", 32'(irq_o), 32'd0);

    // Set beats same-cycle W1C.
    is_broken_i = 12'h0C1;
    acc(1'b1, 1'b1, 8'h08, 32'h1); tick();
    acc(1'b1, 1'b0, 8'h08, 32'h0); tick();
    check("set_wins_w1c", rdata_o, 32'h1);
    is_broken_i = '0;
    acc(1'b1, 1'b1, 8'h08, 32'h3); tick();
    acc(1'b0, 1'b0, 8'h00, 32'h0); tick();

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      int b;
      err_detected_i  = NB'($urandom);
      err_corrected_i = NB'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        b = $urandom_range(0, 3 * NB - 1);
        is_broken_i[b] = ~is_broken_i[b];
      end
      if ($urandom_range(0, 9) == 0)
        acc(1'($urandom), 1'($urandom), 8'($urandom), $urandom);
      else
        acc(1'($urandom), 1'($urandom), 8'(addr_tab[$urandom_range(0, 15)] | $urandom_range(0, 3)), $urandom);
      tick();
    end

    // Reset in the middle of a read.
    acc(1'b1, 1'b0, 8'h0C, 32'h0); tick();
    rst_n = 1'b0;
    #1;
    check("rst_rvalid", 32'(rvalid_o), 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_set_broken", 32'(set_broken_o), 32'd0);
    check("rst_gnt", 32'(gnt_o), 32'd0);
    model_reset();
    repeat (2) begin
      @(negedge clk);
      compare_all();
    end
    rst_n = 1'b1;
    acc(1'b0, 1'b0, 8'h00, 32'h0);
    is_broken_i = 12'h001;
    tick();
    acc(1'b1, 1'b0, 8'h08, 32'h0); tick();
    check("pend_after_rst", rdata_o, 32'h1);
    acc(1'b0, 1'b0, 8'h00, 32'h0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
